// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer for the program 2 core.
// Owns the PC, forwards the decoded branch field to the branch-target LUT,
// and loads the LUT target on taken branches. Implements the bench
// start/done handshake: arm on Start, run when Start falls, and stop on
// halt, on a bad branch index, or when the PC would overflow.
module pc_sequencer #(
   parameter int            PC_W     = 10,
   parameter int            IDX_W    = 8,
   parameter int            NUM_TGT  = 9,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int            CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             BrTaken,
   input  logic [IDX_W-1:0] BrIdx,
   output logic [IDX_W-1:0] LutAddr,
   input  logic [PC_W-1:0]  LutTarget,
   output logic [PC_W-1:0]  PC,
   output logic             Busy,
   output logic             Done,
   output logic             Err,
   output logic [CNT_W-1:0] InstrCnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [PC_W-1:0]  PC_MAX      = '1;
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   // One extra bit so NUM_TGT == 2**IDX_W still compares correctly.
   localparam logic [IDX_W:0]   NUM_TGT_EXT = (IDX_W+1)'(NUM_TGT);

   state_t           state;
   logic             idx_ok;
   logic [CNT_W-1:0] cnt_inc;

   // The LUT is indexed straight from the decoded field, no register.
   assign LutAddr = BrIdx;

   // Branch index is only legal below the number of populated LUT entries.
   assign idx_ok  = ({1'b0, BrIdx} < NUM_TGT_EXT);

   // Retired-instruction counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (InstrCnt == CNT_MAX) ? InstrCnt : InstrCnt + CNT_W'(1);

   // Sequencer FSM with all status outputs registered alongside the state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         PC       <= START_PC;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Err      <= 1'b0;
         InstrCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state    <= ARMED;
                  PC       <= START_PC;
                  InstrCnt <= '0;
                  Err      <= 1'b0;
                  Done     <= 1'b0;
               end
            end

            ARMED: begin
               // Run begins on the falling edge of the Start level.
               if (!Start) begin
                  state <= RUN;
                  Busy  <= 1'b1;
               end
            end

            RUN: begin
               if (Start) begin
                  // Restart mid-run: re-arm from the start address.
                  state    <= ARMED;
                  Busy     <= 1'b0;
                  PC       <= START_PC;
                  InstrCnt <= '0;
                  Err      <= 1'b0;
               end else if (Stall) begin
                  // Nothing retires; Halt/BrTaken are re-presented later.
               end else if (Halt) begin
                  state    <= DONE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  InstrCnt <= cnt_inc;
               end else if (BrTaken && idx_ok) begin
                  PC       <= LutTarget;
                  InstrCnt <= cnt_inc;
               end else if (BrTaken) begin
                  state    <= DONE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  Err      <= 1'b1;
                  InstrCnt <= cnt_inc;
               end else if (PC == PC_MAX) begin
                  // Falling off the end of program space stops the run.
                  state    <= DONE;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  InstrCnt <= cnt_inc;
               end else begin
                  PC       <= PC + PC_W'(1);
                  InstrCnt <= cnt_inc;
               end
            end

            DONE: begin
               if (Start) begin
                  state    <= ARMED;
                  Done     <= 1'b0;
                  PC       <= START_PC;
                  InstrCnt <= '0;
                  Err      <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
